mips_pipe_stage: RTL and testbench
==================================

Name: mips_pipe_stage

Overview:
- Parametrised elastic pipeline register for the MIPS core. It is the generic successor to the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Replaces the plain ENABLE stall with a valid/ready handshake, an optional 2-entry skid buffer, synchronous flush with bubble insertion, and a saturating stall-cycle counter.
- Instantiated between each pair of pipeline stages; the hazard unit drives FLUSH.

Parameters:
- DATA_W, 195, total payload width. The payload is packed {CTRL, PC, RD1, RD2, SIGNEXT, RS, RT, RD, SHIFT}.
- CTRL_W, 20, width of the control field in payload bits [DATA_W-1 -: CTRL_W]. This field is zeroed on bubble or flush.
- SKID, 1, selects the buffering mode.
  - 1: 2-entry skid buffer, with O_READY registered.
  - 0: single entry, with O_READY combinational.
- CNT_W, 16, width of the stall counter.

Ports:
- CLK  in  1  clock
- RESET  in  1  reset; asynchronous, active-high
- FLUSH  in  1  synchronous flush that invalidates all held entries
- I_VALID  in  1  upstream presents data
- O_READY  out  1  stage can accept data
- I_DATA  in  DATA_W  upstream payload
- O_VALID  out  1  output entry valid
- I_READY  in  1  downstream accepts data
- O_DATA  out  DATA_W  payload of the main (output) entry
- O_OCC  out  2  occupancy: 0, 1 or 2
- O_STALL_CNT  out  CNT_W  saturating count of cycles with O_VALID=1 and I_READY=0

Behaviour:
- Reset (asynchronous): all of the following clear to 0.
  - Main and skid entries, valid bits, O_VALID, O_OCC, O_STALL_CNT.
  - O_DATA = 0.
  - O_READY = 1 once RESET deasserts.
- Transfers:
  - An input transfer occurs when I_VALID & O_READY.
  - An output transfer occurs when O_VALID & I_READY.
- Latency is 1 cycle: data accepted at edge n appears on O_DATA after edge n, with O_VALID=1.
- States (SKID=1):
  - EMPTY (occ 0). An input transfer moves to ONE, loading main.
  - ONE (occ 1):
    - Input and output transfer together: stay in ONE, main loads I_DATA.
    - Output transfer only: go to EMPTY.
    - Input transfer only (downstream stalled): go to FULL, skid loads I_DATA.
  - FULL (occ 2): O_READY=0. An output transfer moves skid into main and returns to ONE.
- O_READY (SKID=1) = ~skid_valid, driven from a flop. There is no combinational I_READY-to-O_READY path.
- SKID=0:
  - Only EMPTY and ONE exist.
  - O_READY = ~O_VALID | I_READY.
  - In ONE with a simultaneous input and output transfer, main reloads.
- Bubble: when main becomes invalid (output transfer with no replacement), main's CTRL field clears to 0. The rest of the payload holds its value. Downstream therefore sees a NOP control word whenever O_VALID=0.
- FLUSH:
  - At the next edge, both valid bits clear, both CTRL fields clear to 0, and occupancy goes to 0.
  - FLUSH has priority: an input transfer in the same cycle is dropped. The handshake still completes from upstream's view, because O_READY is not masked.
  - An output transfer in the flush cycle is still valid, since downstream sampled it.
- Stall counter:
  - Increments each cycle with O_VALID & ~I_READY.
  - Saturates at 2^CNT_W-1 (no wrap).
  - Not cleared by FLUSH; cleared only by RESET.
- Data is never lost or duplicated: every input transfer not killed by FLUSH produces exactly one output transfer, in order.
- RESET mid-operation discards all entries immediately, without waiting for a clock edge.

Decomposition:
- Shared package mips_pipe_pkg holds:
  - The state encoding (EMPTY=2'd0, ONE=2'd1, FULL=2'd2).
  - The default field widths (CTRL_W=20, REG_W=5, WORD_W=32).
  - Localparam offsets for packing the ID/EX payload.
- One natural sub-module, mips_sat_counter (parameter W; inputs CLK, RESET, INC; output CNT), used for O_STALL_CNT.

Test Plan:
- Streaming with SKID=1:
  - Stimulus: I_VALID=1 with I_READY=1 held high, data 1..8 with CTRL=20'hABCDE.
  - Required: O_DATA shows 1..8 on consecutive cycles one cycle late; O_READY stays 1; O_STALL_CNT=0.
- Backpressure:
  - Stimulus: stream 1,2,3; drop I_READY for 3 cycles after word 1 appears.
  - Required: O_OCC reaches 2 and O_READY=0. After I_READY returns, output order is exactly 1,2,3 with no duplicates. O_STALL_CNT=3.
- Flush in FULL:
  - Stimulus: state FULL (holding 5,6); assert FLUSH while I_VALID=1 with data 7.
  - Required: next cycle O_VALID=0, O_OCC=0, CTRL bits of O_DATA = 0, and 7 never appears.
- Bubble:
  - Stimulus: a single word with CTRL=20'hFFFFF, followed by I_VALID=0 and I_READY=1.
  - Required: after it drains, O_VALID=0 with CTRL=0 and the remaining payload bits unchanged.
- SKID=0 instance:
  - Stimulus: stall downstream with main holding word 9.
  - Required: O_READY=0 in the same cycle I_READY=0. When I_READY rises, O_READY=1 combinationally and the new word replaces 9 at the next edge.
- Asynchronous reset and counter saturation:
  - Stimulus: assert RESET between clock edges while FULL.
  - Required: outputs zero immediately.
  - Stimulus: with CNT_W=4, stall for 20 cycles.
  - Required: O_STALL_CNT saturates at 15.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS elastic pipeline stage: occupancy encoding,
// default field widths and ID/EX payload packing offsets.
package mips_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  localparam int unsigned DEF_CTRL_W = 20;
  localparam int unsigned REG_W      = 5;
  localparam int unsigned WORD_W     = 32;

  // ID/EX payload, LSB first: SHIFT, RD, RT, RS, SIGNEXT, RD2, RD1, PC, CTRL
  localparam int unsigned SHIFT_LSB   = 0;
  localparam int unsigned RD_LSB      = SHIFT_LSB + WORD_W;
  localparam int unsigned RT_LSB      = RD_LSB + REG_W;
  localparam int unsigned RS_LSB      = RT_LSB + REG_W;
  localparam int unsigned SIGNEXT_LSB = RS_LSB + REG_W;
  localparam int unsigned RD2_LSB     = SIGNEXT_LSB + WORD_W;
  localparam int unsigned RD1_LSB     = RD2_LSB + WORD_W;
  localparam int unsigned PC_LSB      = RD1_LSB + WORD_W;
  localparam int unsigned CTRL_LSB    = PC_LSB + WORD_W;
  localparam int unsigned IDEX_W      = CTRL_LSB + DEF_CTRL_W;

endpackage

// File: rtl/mips_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module mips_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         INC,
  output logic [W-1:0] CNT
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (INC && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign CNT = cnt_q;

endmodule

// File: rtl/mips_pipe_stage.sv
// Elastic inter-stage pipeline register with valid/ready handshake, optional
// skid entry, flush with bubble insertion and a saturating stall counter.
module mips_pipe_stage
  import mips_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = IDEX_W,
  parameter int unsigned CTRL_W = DEF_CTRL_W,
  parameter bit          SKID   = 1'b1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FLUSH,
  input  logic              I_VALID,
  output logic              O_READY,
  input  logic [DATA_W-1:0] I_DATA,
  output logic              O_VALID,
  input  logic              I_READY,
  output logic [DATA_W-1:0] O_DATA,
  output logic [1:0]        O_OCC,
  output logic [CNT_W-1:0]  O_STALL_CNT
);

  pipe_state_e       state_q;
  logic              main_valid_q, skid_valid_q;
  logic [DATA_W-1:0] main_q, skid_q;
  logic              in_xfer, out_xfer, stall;

  // An invalid entry must present a NOP control word downstream
  function automatic logic [DATA_W-1:0] kill_ctrl(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = d;
    r[DATA_W-1 -: CTRL_W] = '0;
    return r;
  endfunction

  if (SKID) begin : g_skid
    assign O_READY = ~skid_valid_q;
  end else begin : g_noskid
    assign O_READY = ~main_valid_q | I_READY;
  end

  assign in_xfer  = I_VALID & O_READY;
  assign out_xfer = main_valid_q & I_READY;
  assign stall    = main_valid_q & ~I_READY;

  // Occupancy FSM and entry storage; FLUSH wins over any input transfer
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_EMPTY;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else if (FLUSH) begin
      state_q      <= ST_EMPTY;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= kill_ctrl(main_q);
      skid_q       <= kill_ctrl(skid_q);
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_q       <= I_DATA;
            main_valid_q <= 1'b1;
            state_q      <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_q <= I_DATA;
          end else if (out_xfer) begin
            main_q       <= kill_ctrl(main_q);
            main_valid_q <= 1'b0;
            state_q      <= ST_EMPTY;
          end else if (in_xfer && SKID) begin
            skid_q       <= I_DATA;
            skid_valid_q <= 1'b1;
            state_q      <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            main_q       <= skid_q;
            skid_q       <= kill_ctrl(skid_q);
            skid_valid_q <= 1'b0;
            state_q      <= ST_ONE;
          end
        end
        default: begin
          state_q      <= ST_EMPTY;
          main_valid_q <= 1'b0;
          skid_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign O_VALID = main_valid_q;
  assign O_DATA  = main_q;
  assign O_OCC   = state_q;

  mips_sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .CLK  (CLK),
    .RESET(RESET),
    .INC  (stall),
    .CNT  (O_STALL_CNT)
  );

endmodule

// File: tb/tb_mips_pipe_stage.sv
// Scoreboard bench for mips_pipe_stage: skid, non-skid and 4-bit-counter
// instances driven with directed vectors.
module tb_mips_pipe_stage;

  localparam int unsigned DW = 195;

  logic clk, rst;

  logic          a_flush, a_ivalid, a_oready, a_ovalid, a_iready;
  logic [DW-1:0] a_idata, a_odata;
  logic [1:0]    a_occ;
  logic [15:0]   a_cnt;

  logic          b_flush, b_ivalid, b_oready, b_ovalid, b_iready;
  logic [DW-1:0] b_idata, b_odata;
  logic [1:0]    b_occ;
  logic [15:0]   b_cnt;

  logic          c_flush, c_ivalid, c_oready, c_ovalid, c_iready;
  logic [DW-1:0] c_idata, c_odata;
  logic [1:0]    c_occ;
  logic [3:0]    c_cnt;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  logic [DW-1:0] ea, eb;

  mips_pipe_stage #(.SKID(1'b1), .CNT_W(16)) u_dut_a (
    .CLK(clk), .RESET(rst), .FLUSH(a_flush), .I_VALID(a_ivalid), .O_READY(a_oready),
    .I_DATA(a_idata), .O_VALID(a_ovalid), .I_READY(a_iready), .O_DATA(a_odata),
    .O_OCC(a_occ), .O_STALL_CNT(a_cnt));

  mips_pipe_stage #(.SKID(1'b0), .CNT_W(16)) u_dut_b (
    .CLK(clk), .RESET(rst), .FLUSH(b_flush), .I_VALID(b_ivalid), .O_READY(b_oready),
    .I_DATA(b_idata), .O_VALID(b_ovalid), .I_READY(b_iready), .O_DATA(b_odata),
    .O_OCC(b_occ), .O_STALL_CNT(b_cnt));

  mips_pipe_stage #(.SKID(1'b1), .CNT_W(4)) u_dut_c (
    .CLK(clk), .RESET(rst), .FLUSH(c_flush), .I_VALID(c_ivalid), .O_READY(c_oready),
    .I_DATA(c_idata), .O_VALID(c_ovalid), .I_READY(c_iready), .O_DATA(c_odata),
    .O_OCC(c_occ), .O_STALL_CNT(c_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk(input logic [19:0] c, input logic [31:0] v);
    return {c, 143'(0), v};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drv_a(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    a_ivalid = v; a_idata = d; a_iready = r; a_flush = f;
    #1;
    if (v && a_oready && !f) qa.push_back(d);
  endtask

  task automatic drv_b(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    b_ivalid = v; b_idata = d; b_iready = r; b_flush = f;
    #1;
    if (v && b_oready && !f) qb.push_back(d);
  endtask

  // Flushed entries are never delivered, so drop them from the expectations
  task automatic tick;
    @(posedge clk);
    #1;
    if (a_flush) qa.delete();
    if (b_flush) qb.delete();
  endtask

  // Monitor: every output transfer must match the oldest expected word
  always @(negedge clk) begin
    if (!rst) begin
      if (a_ovalid && a_iready) begin
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected_out actual=%h required=none", a_odata);
        end else begin
          ea = qa.pop_front();
          chk("a_out_data", a_odata, ea);
        end
      end
      if (b_ovalid && b_iready) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected_out actual=%h required=none", b_odata);
        end else begin
          eb = qb.pop_front();
          chk("b_out_data", b_odata, eb);
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    a_flush = 0; a_ivalid = 0; a_iready = 0; a_idata = '0;
    b_flush = 0; b_ivalid = 0; b_iready = 0; b_idata = '0;
    c_flush = 0; c_ivalid = 0; c_iready = 0; c_idata = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst_valid", 195'(a_ovalid), 195'(0));
    chk("rst_data",  a_odata, '0);
    chk("rst_occ",   195'(a_occ), 195'(0));
    chk("rst_cnt",   195'(a_cnt), 195'(0));
    #9 rst = 1'b0;
    #1;
    chk("rst_ready", 195'(a_oready), 195'(1));
    tick;

    // Streaming, downstream always ready
    for (int i = 1; i <= 8; i++) begin
      drv_a(1'b1, mk(20'hABCDE, 32'(i)), 1'b1, 1'b0);
      chk("stream_ready", 195'(a_oready), 195'(1));
      tick;
      if (i == 1) chk("stream_latency", a_odata, mk(20'hABCDE, 32'd1));
    end
    drv_a(1'b0, '0, 1'b1, 1'b0);
    tick;
    chk("stream_bubble_data", a_odata, mk(20'h0, 32'd8));
    chk("stream_valid_end", 195'(a_ovalid), 195'(0));
    chk("stream_occ_end", 195'(a_occ), 195'(0));
    chk("stream_cnt", 195'(a_cnt), 195'(0));

    // Backpressure: three stalled cycles with word 1 at the output
    drv_a(1'b1, mk(20'h11111, 32'd1), 1'b1, 1'b0); tick;
    drv_a(1'b1, mk(20'h11111, 32'd2), 1'b0, 1'b0); tick;
    chk("bp_occ_full", 195'(a_occ), 195'(2));
    chk("bp_ready_low", 195'(a_oready), 195'(0));
    drv_a(1'b1, mk(20'h11111, 32'd3), 1'b0, 1'b0); tick;
    drv_a(1'b1, mk(20'h11111, 32'd3), 1'b0, 1'b0); tick;
    drv_a(1'b1, mk(20'h11111, 32'd3), 1'b1, 1'b0); tick;
    chk("bp_ready_back", 195'(a_oready), 195'(1));
    drv_a(1'b1, mk(20'h11111, 32'd3), 1'b1, 1'b0); tick;
    drv_a(1'b0, '0, 1'b1, 1'b0); tick;
    chk("bp_cnt", 195'(a_cnt), 195'(3));
    chk("bp_occ_end", 195'(a_occ), 195'(0));
    chk("bp_drained", 195'(qa.size()), 195'(0));

    // Flush while FULL holding 5,6 with 7 offered
    drv_a(1'b1, mk(20'h22222, 32'd5), 1'b0, 1'b0); tick;
    drv_a(1'b1, mk(20'h22222, 32'd6), 1'b0, 1'b0); tick;
    chk("fl_occ_full", 195'(a_occ), 195'(2));
    drv_a(1'b1, mk(20'h22222, 32'd7), 1'b0, 1'b1); tick;
    chk("fl_valid", 195'(a_ovalid), 195'(0));
    chk("fl_occ", 195'(a_occ), 195'(0));
    chk("fl_data_ctrl0", a_odata, mk(20'h0, 32'd5));
    chk("fl_ready", 195'(a_oready), 195'(1));
    drv_a(1'b0, '0, 1'b1, 1'b0); tick; tick;
    chk("fl_cnt_kept", 195'(a_cnt), 195'(5));

    // Flush in ONE drops an input that was handshaken the same cycle
    drv_a(1'b1, mk(20'h33333, 32'd9), 1'b0, 1'b0); tick;
    drv_a(1'b1, mk(20'h33333, 32'd10), 1'b0, 1'b1); tick;
    chk("fl1_valid", 195'(a_ovalid), 195'(0));
    chk("fl1_occ", 195'(a_occ), 195'(0));
    drv_a(1'b0, '0, 1'b1, 1'b0); tick; tick;
    chk("fl1_cnt", 195'(a_cnt), 195'(6));

    // Bubble after a single word
    drv_a(1'b1, mk(20'hFFFFF, 32'h1234), 1'b1, 1'b0); tick;
    chk("bub_loaded", a_odata, mk(20'hFFFFF, 32'h1234));
    drv_a(1'b0, '0, 1'b1, 1'b0); tick;
    chk("bub_valid", 195'(a_ovalid), 195'(0));
    chk("bub_data", a_odata, mk(20'h0, 32'h1234));

    // Non-skid instance: combinational ready
    drv_b(1'b1, mk(20'h44444, 32'd9), 1'b1, 1'b0); tick;
    b_ivalid = 1'b1; b_idata = mk(20'h44444, 32'd11); b_iready = 1'b0;
    #1;
    chk("ns_ready_low", 195'(b_oready), 195'(0));
    tick;
    chk("ns_hold", b_odata, mk(20'h44444, 32'd9));
    drv_b(1'b1, mk(20'h44444, 32'd11), 1'b1, 1'b0);
    chk("ns_ready_high", 195'(b_oready), 195'(1));
    tick;
    chk("ns_replace", b_odata, mk(20'h44444, 32'd11));
    drv_b(1'b0, '0, 1'b1, 1'b0); tick;
    chk("ns_valid_end", 195'(b_ovalid), 195'(0));
    chk("ns_cnt", 195'(b_cnt), 195'(1));
    chk("ns_drained", 195'(qb.size()), 195'(0));

    // 4-bit counter saturation
    c_ivalid = 1'b1; c_idata = mk(20'h55555, 32'd1); c_iready = 1'b0;
    tick;
    c_ivalid = 1'b0;
    repeat (10) tick;
    chk("sat_mid", 195'(c_cnt), 195'(10));
    repeat (10) tick;
    chk("sat_max", 195'(c_cnt), 195'(15));

    // Asynchronous reset while FULL
    drv_a(1'b1, mk(20'h66666, 32'd20), 1'b0, 1'b0); tick;
    drv_a(1'b1, mk(20'h66666, 32'd21), 1'b0, 1'b0); tick;
    chk("ar_occ_full", 195'(a_occ), 195'(2));
    a_ivalid = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("ar_valid", 195'(a_ovalid), 195'(0));
    chk("ar_occ", 195'(a_occ), 195'(0));
    chk("ar_data", a_odata, '0);
    chk("ar_cnt", 195'(a_cnt), 195'(0));
    chk("ar_c_cnt", 195'(c_cnt), 195'(0));
    qa.delete();
    qb.delete();
    #2 rst = 1'b0;
    #1;
    chk("ar_ready", 195'(a_oready), 195'(1));
    tick;
    chk("end_qa", 195'(qa.size()), 195'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
